serial_adder: RTL and testbench

//   Bit-serial, LSB-first two's-complement adder; companion (inverse operation) to the 8-bit subtractor.

---
 rtl/serial_adder_pkg.sv | 24 ++
 rtl/full_adder_1b.sv | 15 +
 rtl/serial_adder.sv | 119 +++++++++++
 tb/tb_serial_adder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM encoding, width limits,
// and the carry logic used by the single full-adder cell.
package serial_adder_pkg;

    localparam int unsigned WIDTH_MIN = 2;
    localparam int unsigned WIDTH_MAX = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Bit-counter width; guarded so a 1-bit counter is still produced for tiny widths.
    function automatic int unsigned cnt_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    // Carry of a full adder is the majority of its three inputs.
    function automatic logic maj3(input logic x, input logic y, input logic z);
        return (x & y) | (x & z) | (y & z);
    endfunction

endpackage : serial_adder_pkg

// File: rtl/full_adder_1b.sv
// Single-bit full adder cell, purely combinational.
module full_adder_1b
    import serial_adder_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = maj3(a, b, ci);

endmodule : full_adder_1b

// File: rtl/serial_adder.sv
// Bit-serial LSB-first adder: one full-adder cell reused for WIDTH clocks.
// Optional signed-overflow output is enabled by defining SADD_OVF_EN.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SADD_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
    logic             fa_s;
    logic             fa_co;
    logic             last_bit;
`ifdef SADD_OVF_EN
    logic             ovf_q;
`endif

    // Shared adder cell always looks at the current LSBs and running carry.
    full_adder_1b u_fa (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign last_bit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SADD_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a;
                        b_sh_q  <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // sum doubles as the result shift register; bits enter at the MSB.
                    sum_q   <= {fa_s, sum_q[WIDTH-1:1]};
                    a_sh_q  <= {1'b0, a_sh_q[WIDTH-1:1]};
                    b_sh_q  <= {1'b0, b_sh_q[WIDTH-1:1]};
                    carry_q <= fa_co;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (last_bit) begin
                        cout_q  <= fa_co;
`ifdef SADD_OVF_EN
                        // carry_q is the carry into the MSB on this edge.
                        ovf_q   <= carry_q ^ fa_co;
`endif
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SADD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// Directed and randomised self-checking bench for serial_adder (WIDTH=8).
// Overflow checks are compiled in when SADD_OVF_EN is defined.
module tb_serial_adder;

    localparam int unsigned W   = 8;
    localparam int          PER = W + 2;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SADD_OVF_EN
    logic         ovf;
`endif

    int total;
    int bad;

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SADD_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Present operands for one cycle; returns just after the accepting edge.
    task automatic start_add(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vc);
        a     = va;
        b     = vb;
        cin   = vc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count edges until done is seen (bounded).
    task automatic wait_done(output int edges, output bit seen);
        edges = 0;
        seen  = 1'b0;
        for (int i = 0; i < 4 * PER; i++) begin
            @(posedge clk);
            #1;
            edges++;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int edges;
        bit seen;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL reset_cout got=%b want=0", cout); end
`ifdef SADD_OVF_EN
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b want=0", ovf); end
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;
        start_add(8'd3, 8'd1, 1'b0);
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL first_busy got=%b want=1", busy); end
        wait_done(edges, seen);
        total++; if (!seen) begin bad++; $display("FAIL first_timeout done not seen"); end
        total++; if (edges != W) begin bad++; $display("FAIL first_latency got=%0d want=%0d", edges, W); end
        total++; if (sum !== 8'd4) begin bad++; $display("FAIL first_sum got=%h want=04", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL first_cout got=%b want=0", cout); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [W-1:0] va [2] = '{8'hF8, 8'h4C};
        logic [W-1:0] vb [2] = '{8'h02, 8'h15};
        logic         vc [2] = '{1'b0, 1'b1};
        logic [W-1:0] es [2] = '{8'hFA, 8'h62};
        int edges;
        bit seen;
        for (int i = 0; i < 2; i++) begin
            start_add(va[i], vb[i], vc[i]);
            wait_done(edges, seen);
            total++; if (!seen) begin bad++; $display("FAIL basic_timeout idx=%0d", i); end
            total++; if (sum !== es[i]) begin bad++; $display("FAIL basic_sum idx=%0d got=%h want=%h", i, sum, es[i]); end
            total++; if (cout !== 1'b0) begin bad++; $display("FAIL basic_cout idx=%0d got=%b want=0", i, cout); end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_wrap();
        logic [W-1:0] va [3] = '{8'hFF, 8'h7F, 8'h81};
        logic [W-1:0] vb [3] = '{8'h01, 8'h01, 8'h81};
        logic [W-1:0] es [3] = '{8'h00, 8'h80, 8'h02};
        logic         ec [3] = '{1'b1, 1'b0, 1'b1};
        logic         eo [3] = '{1'b0, 1'b1, 1'b1};
        int edges;
        bit seen;
        for (int i = 0; i < 3; i++) begin
            start_add(va[i], vb[i], 1'b0);
            wait_done(edges, seen);
            total++; if (!seen) begin bad++; $display("FAIL wrap_timeout idx=%0d", i); end
            total++; if (sum !== es[i]) begin bad++; $display("FAIL wrap_sum idx=%0d got=%h want=%h", i, sum, es[i]); end
            total++; if (cout !== ec[i]) begin bad++; $display("FAIL wrap_cout idx=%0d got=%b want=%b", i, cout, ec[i]); end
`ifdef SADD_OVF_EN
            total++; if (ovf !== eo[i]) begin bad++; $display("FAIL wrap_ovf idx=%0d got=%b want=%b", i, ovf, eo[i]); end
`else
            if (eo[i] === 1'bx) $display("unreachable");
`endif
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_start_held();
        int   ndone;
        logic exp_busy;
        logic exp_done;
        logic prev_done;
        ndone     = 0;
        prev_done = 1'b0;
        a         = 8'd6;
        b         = 8'd3;
        cin       = 1'b0;
        start     = 1'b1;
        for (int n = 1; n <= 2 * PER; n++) begin
            @(posedge clk);
            #1;
            exp_busy = ((n % PER) != 0);
            exp_done = ((n % PER) == PER - 1);
            total++; if (busy !== exp_busy) begin bad++; $display("FAIL held_busy n=%0d got=%b want=%b", n, busy, exp_busy); end
            total++; if (done !== exp_done) begin bad++; $display("FAIL held_done n=%0d got=%b want=%b", n, done, exp_done); end
            total++; if (prev_done && done) begin bad++; $display("FAIL held_done_width n=%0d got=2 cycles want=1", n); end
            if (done === 1'b1) begin
                ndone++;
                if (ndone == 1) begin
                    total++; if (sum !== 8'd9) begin bad++; $display("FAIL held_sum got=%h want=09", sum); end
                end
            end
            prev_done = done;
        end
        start = 1'b0;
        total++; if (ndone != 2) begin bad++; $display("FAIL held_count got=%0d want=2", ndone); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_input_change();
        int edges;
        bit seen;
        int ndone;
        start_add(8'h5A, 8'h33, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        a   = 8'h00;
        b   = 8'h00;
        cin = 1'b1;
        wait_done(edges, seen);
        total++; if (!seen) begin bad++; $display("FAIL change_timeout"); end
        total++; if (sum !== 8'h8D) begin bad++; $display("FAIL change_sum got=%h want=8d", sum); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL change_cout got=%b want=0", cout); end
        @(posedge clk);
        #1;
        start_add(8'hC3, 8'h5A, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL abort_sum got=%h want=00", sum); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
        total++; if (cout !== 1'b0) begin bad++; $display("FAIL abort_cout got=%b want=0", cout); end
        ndone = 0;
        for (int i = 0; i < 2 * PER; i++) begin
            if (done === 1'b1) ndone++;
            @(posedge clk);
            #1;
        end
        total++; if (ndone != 0) begin bad++; $display("FAIL abort_done got=%0d pulses want=0", ndone); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_idle_busy got=%b want=0", busy); end
    endtask

    task automatic test_random();
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic         rc;
        logic [W:0]   ref_full;
        logic         ref_ovf;
        logic [W-1:0] held;
        int edges;
        bit seen;
        for (int i = 0; i < 500; i++) begin
            ra       = W'($urandom_range(255));
            rb       = W'($urandom_range(255));
            rc       = 1'($urandom_range(1));
            ref_full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            ref_ovf  = (ra[W-1] == rb[W-1]) && (ref_full[W-1] != ra[W-1]);
            start_add(ra, rb, rc);
            wait_done(edges, seen);
            total++; if (!seen) begin bad++; $display("FAIL rand_timeout i=%0d", i); end
            total++; if (sum !== ref_full[W-1:0]) begin bad++; $display("FAIL rand_sum a=%h b=%h c=%b got=%h want=%h", ra, rb, rc, sum, ref_full[W-1:0]); end
            total++; if (cout !== ref_full[W]) begin bad++; $display("FAIL rand_cout a=%h b=%h c=%b got=%b want=%b", ra, rb, rc, cout, ref_full[W]); end
`ifdef SADD_OVF_EN
            total++; if (ovf !== ref_ovf) begin bad++; $display("FAIL rand_ovf a=%h b=%h c=%b got=%b want=%b", ra, rb, rc, ovf, ref_ovf); end
`else
            if (ref_ovf === 1'bx) $display("unreachable");
`endif
            held = sum;
            @(posedge clk);
            #1;
            total++; if (done !== 1'b0) begin bad++; $display("FAIL rand_done_width i=%0d got=%b want=0", i, done); end
            for (int k = 0; k < int'($urandom_range(2)); k++) begin
                @(posedge clk);
                #1;
            end
            total++; if (sum !== held || cout !== ref_full[W]) begin
                bad++; $display("FAIL rand_hold i=%0d got=%h/%b want=%h/%b", i, sum, cout, held, ref_full[W]);
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_start_held();
        test_input_change();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_serial_adder
